// File: rtl/range_stream_tx_pkg.sv
// Shared types and defaults for the range-finder stream transmitter.
package range_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;
    localparam int CNT_W      = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/range_stream_tx_if.sv
// Load/start/stream/status bundle between the transmitter and its user.
interface range_stream_tx_if
    import range_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_go;
    logic              tx_finish;
    logic              busy;
    logic              done;
    logic              start_err;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] expected_range;

    modport master (
        output load_valid, load_data, start,
        input  load_ready, tx_data, tx_go, tx_finish, busy, done,
               start_err, count, expected_range
    );

    modport slave (
        input  load_valid, load_data, start,
        output load_ready, tx_data, tx_go, tx_finish, busy, done,
               start_err, count, expected_range
    );
endinterface

// File: rtl/range_stream_tx_sample_buf.sv
// DEPTH x DATA_W sample register file: one write port, one asynchronous read port.
module sample_buf
    import range_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_we,
    input  logic [CNT_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [CNT_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int               AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Sample storage; out-of-range writes are dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr < DEPTH_C)) begin
            r_mem[i_waddr[AW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = (i_raddr < DEPTH_C) ? r_mem[i_raddr[AW-1:0]] : '0;

endmodule

// File: rtl/range_stream_tx.sv
// Buffers samples, streams them as a framed burst and reports the frame's max-min range.
module range_stream_tx
    import range_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    range_stream_tx_if.slave    bus
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_range;
    logic              r_done;
    logic              r_start_err;

    logic [DATA_W-1:0] w_rdata;
    logic              w_send;
    logic              w_load_ready;
    logic              w_load_fire;
    logic [CNT_W-1:0]  w_count_post;
    logic              w_go;
    logic              w_finish;
    logic              w_start_ok;
    logic              w_start_rej;
    logic [DATA_W-1:0] w_max_upd;
    logic [DATA_W-1:0] w_min_upd;

    sample_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_buf (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_load_fire),
        .i_waddr (r_count),
        .i_wdata (bus.load_data),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

    assign w_send       = (r_state == SEND);
    assign w_load_ready = (r_state == IDLE) && (r_count < DEPTH_C);
    assign w_load_fire  = w_load_ready && bus.load_valid;
    // A load coinciding with start counts toward the start decision.
    assign w_count_post = r_count + CNT_W'(w_load_fire);
    assign w_go         = w_send && (r_idx == {CNT_W{1'b0}});
    assign w_finish     = w_send && (r_idx == (r_count - 4'd1));

    // Next-state and start acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_start_rej = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_count_post >= 4'd2) begin
                        w_state_nxt = SEND;
                        w_start_ok  = 1'b1;
                    end else begin
                        w_start_rej = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                if (w_finish) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = SEND;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Running extremes including the sample currently on the stream.
    always_comb begin
        w_max_upd = r_max;
        w_min_upd = r_min;
        if (w_go) begin
            w_max_upd = w_rdata;
            w_min_upd = w_rdata;
        end else begin
            w_max_upd = (w_rdata > r_max) ? w_rdata : r_max;
            w_min_upd = (w_rdata < r_min) ? w_rdata : r_min;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fill level, stream index, range tracking and status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_idx       <= '0;
            r_max       <= '0;
            r_min       <= '0;
            r_range     <= '0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_done      <= w_finish;
            r_start_err <= w_start_rej;
            if (w_finish) begin
                r_count <= '0;
            end else if (w_load_fire) begin
                r_count <= r_count + 4'd1;
            end
            if (w_start_ok || w_finish) begin
                r_idx <= '0;
            end else if (w_send) begin
                r_idx <= r_idx + 4'd1;
            end
            if (w_send) begin
                r_max <= w_max_upd;
                r_min <= w_min_upd;
            end
            if (w_finish) begin
                r_range <= w_max_upd - w_min_upd;
            end
        end
    end

    assign bus.load_ready     = w_load_ready;
    assign bus.tx_data        = w_send ? w_rdata : '0;
    assign bus.tx_go          = w_go;
    assign bus.tx_finish      = w_finish;
    assign bus.busy           = w_send;
    assign bus.done           = r_done;
    assign bus.start_err      = r_start_err;
    assign bus.count          = r_count;
    assign bus.expected_range = r_range;

endmodule

// File: doc/range_stream_tx.md
RANGE_STREAM_TX -- requirements
Module: range_stream_tx

Interface
REQ-001 Parameter DEPTH, default 8, SHALL be the sample buffer capacity (legal range 2..15).
REQ-002 Parameter DATA_W, default 8, SHALL be the sample width.
REQ-003 clock  input  1  SHALL be the sole clock; all state updates on rising edge.
REQ-004 reset  input  1  SHALL be the reset, asynchronous, active-high.
REQ-005 load_valid  input  1  SHALL indicate that load_data holds a sample to enqueue.
REQ-006 load_data  input  DATA_W  SHALL carry the sample to enqueue.
REQ-007 load_ready  output  1  SHALL be high when in IDLE and count < DEPTH.
REQ-008 start  input  1  SHALL request transmission of the buffered frame.
REQ-009 tx_data  output  DATA_W  SHALL carry the stream sample to the range-finder receiver.
REQ-010 tx_go  output  1  SHALL mark the first sample of a frame.
REQ-011 tx_finish  output  1  SHALL mark the last sample of a frame.
REQ-012 busy  output  1  SHALL be high while in SEND.
REQ-013 done  output  1  SHALL pulse one cycle after the tx_finish cycle.
REQ-014 start_err  output  1  SHALL pulse when start is rejected.
REQ-015 count  output  4  SHALL report the number of buffered samples.
REQ-016 expected_range  output  DATA_W  SHALL hold max-min of the last transmitted frame.

Function
REQ-017 The block SHALL have states IDLE and SEND.
REQ-018 In IDLE, load_valid && load_ready SHALL write load_data to buf[count] and increment count.
REQ-019 In IDLE, start with count >= 2 SHALL enter SEND next cycle with index idx = 0.
REQ-020 In IDLE, start with count < 2 SHALL pulse start_err for one cycle; state, count and buffer unchanged.
REQ-021 When start and an accepted load coincide in IDLE, the load SHALL complete first and the start decision SHALL use the post-load count.
REQ-022 In SEND: tx_data = buf[idx], tx_go = (idx == 0), tx_finish = (idx == count-1), all combinational from registered idx/count/state.
REQ-023 tx_go and tx_finish SHALL never be high in the same cycle.
REQ-024 idx SHALL increment once per cycle in SEND with no gaps; frame length = count cycles.
REQ-025 On the tx_finish cycle, next state SHALL be IDLE, count SHALL clear to 0, done SHALL assert the following cycle.
REQ-026 In IDLE: tx_data = 0, tx_go = 0, tx_finish = 0.
REQ-027 start and load_valid SHALL be ignored in SEND; load_ready = 0 in SEND.
REQ-028 Running max/min SHALL load from buf[0] on the tx_go cycle and update on each later SEND cycle using unsigned comparison.
REQ-029 expected_range SHALL update to final max-min (unsigned, DATA_W bits, never negative) in the cycle done asserts, and hold until the next frame's done.

Reset
REQ-030 reset SHALL force state = IDLE, count = 0, idx = 0, max = min = 0, expected_range = 0, done = 0, start_err = 0; all outputs 0 except load_ready = 1.
REQ-031 reset mid-SEND SHALL abort the frame with tx_finish never asserted; buffer contents need not be reset.

Structure
REQ-032 Package range_pkg SHALL hold DATA_W default, the state enum (IDLE, SEND) and DEPTH default.
REQ-033 Sub-module sample_buf (DEPTH x DATA_W register file, one write port, one async read port) SHALL hold the samples.

Verification
REQ-034 Load 10, 40, 25, 5; start -> 4-cycle frame: go with 10, 40, 25, finish with 5; done next cycle; expected_range = 35; count = 0.
REQ-035 Load 7; start -> start_err pulse, no tx_go, count stays 1; load 7 again, start -> frame 7, 7; expected_range = 0.
REQ-036 Load 8 samples (0, 255, 1..6) -> load_ready low at count = 8, ninth load dropped; start -> frame of 8; expected_range = 255.
REQ-037 Assert start and load_valid during SEND -> no effect on frame or count; load_ready = 0 throughout.
REQ-038 Assert reset at idx = 2 of a 5-sample frame -> tx_* low immediately, tx_finish never seen, count = 0, expected_range = 0.
REQ-039 Same-cycle load (count 1 -> 2) and start -> frame starts next cycle with 2 samples; no start_err.
